// File: rtl/minibyte_bus_if.sv
// minibyte_bus_if: external-bus sequencer between the minibyte CPU memory
// port and the tile pins. A one-cycle CPU request becomes a timed pin cycle
// (address setup, write strobe / read sample window, hold), then a
// one-cycle ack.
//
// Optional feature macro: MINIBYTE_BUSIF_RANGE_CHECK_EN
//   defined   : requests with addr_in[7]=1 complete immediately with err_out,
//               no pin activity, reads return 8'h00, writes are dropped.
//   undefined : addr_in[7] is ignored (aliases into the 7-bit pin space),
//               err_out is tied low.
//
// Handshake: req_in/wr_in/addr_in/wdata_in are sampled only while idle
// (busy_out=0); the access is complete in the single cycle ack_out=1, and
// rdata_out is valid from that cycle until the next read completes.
module minibyte_bus_if #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       req_in,
    input  logic       wr_in,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata_in,
    output logic       ack_out,
    output logic [7:0] rdata_out,
    output logic       busy_out,
    output logic       err_out,
    output logic [6:0] pin_addr_out,
    output logic [7:0] pin_data_out,
    input  logic [7:0] pin_data_in,
    output logic       pin_we_out,
    output logic       pin_drive_out
);

    // Reject out-of-range timing parameters at elaboration.
    generate
        if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
            STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
            HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_params
            $error("minibyte_bus_if: SETUP/STROBE/HOLD_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;
    logic       range_hit;

`ifdef MINIBYTE_BUSIF_RANGE_CHECK_EN
    logic err_q;
    assign range_hit = addr_in[7];
    assign err_out   = err_q;
`else
    logic unused_addr_msb;
    assign unused_addr_msb = addr_in[7];
    assign range_hit       = 1'b0;
    assign err_out         = 1'b0;
`endif

    // Sequencer: every output is registered and set for the state being
    // entered, so nothing on the pins depends combinationally on req_in.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            wr_q          <= 1'b0;
            ack_out       <= 1'b0;
            rdata_out     <= 8'h00;
            busy_out      <= 1'b0;
            pin_addr_out  <= 7'h00;
            pin_data_out  <= 8'h00;
            pin_we_out    <= 1'b0;
            pin_drive_out <= 1'b0;
`ifdef MINIBYTE_BUSIF_RANGE_CHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            ack_out <= 1'b0;
`ifdef MINIBYTE_BUSIF_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    pin_we_out    <= 1'b0;
                    pin_drive_out <= 1'b0;
                    busy_out      <= 1'b0;
                    if (req_in) begin
                        wr_q     <= wr_in;
                        busy_out <= 1'b1;
                        if (range_hit) begin
                            // Out-of-range: straight to DONE, pins untouched.
                            state   <= DONE;
                            ack_out <= 1'b1;
`ifdef MINIBYTE_BUSIF_RANGE_CHECK_EN
                            err_q   <= 1'b1;
`endif
                            if (!wr_in) begin
                                rdata_out <= 8'h00;
                            end
                        end else begin
                            pin_addr_out  <= addr_in[6:0];
                            pin_data_out  <= wdata_in;
                            pin_drive_out <= wr_in;
                            cnt           <= SETUP_LOAD;
                            state         <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        cnt           <= STROBE_LOAD;
                        state         <= STROBE;
                        pin_we_out    <= wr_q;
                        pin_drive_out <= wr_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        cnt           <= HOLD_LOAD;
                        state         <= HOLD;
                        pin_we_out    <= 1'b0;
                        pin_drive_out <= wr_q;
                        if (!wr_q) begin
                            rdata_out <= pin_data_in;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state         <= DONE;
                        pin_drive_out <= 1'b0;
                        ack_out       <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    busy_out      <= 1'b0;
                    pin_we_out    <= 1'b0;
                    pin_drive_out <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    busy_out      <= 1'b0;
                    pin_we_out    <= 1'b0;
                    pin_drive_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minibyte_bus_if.sv
// Bench for minibyte_bus_if: clock/reset block, directed driver tasks,
// a cycle-position reference model, an expected read-data queue and a
// per-cycle compare process, then a one-line report.
module tb_minibyte_bus_if;

    localparam int S  = 1;
    localparam int ST = 2;
    localparam int H  = 1;
    localparam int T_NORM = S + ST + H + 1;
`ifdef MINIBYTE_BUSIF_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       req_in = 1'b0;
    logic       wr_in = 1'b0;
    logic [7:0] addr_in = 8'h00;
    logic [7:0] wdata_in = 8'h00;
    logic [7:0] pin_data_in = 8'hFF;
    logic       ack_out;
    logic [7:0] rdata_out;
    logic       busy_out;
    logic       err_out;
    logic [6:0] pin_addr_out;
    logic [7:0] pin_data_out;
    logic       pin_we_out;
    logic       pin_drive_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int ack_total = 0;

    minibyte_bus_if #(
        .SETUP_CYCLES(S),
        .STROBE_CYCLES(ST),
        .HOLD_CYCLES(H)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_in(req_in),
        .wr_in(wr_in),
        .addr_in(addr_in),
        .wdata_in(wdata_in),
        .ack_out(ack_out),
        .rdata_out(rdata_out),
        .busy_out(busy_out),
        .err_out(err_out),
        .pin_addr_out(pin_addr_out),
        .pin_data_out(pin_data_out),
        .pin_data_in(pin_data_in),
        .pin_we_out(pin_we_out),
        .pin_drive_out(pin_drive_out)
    );

    // clock
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_t = position of the current cycle inside an access (1..done), 0 = idle.
    int         m_t = 0;
    logic       m_wr = 1'b0;
    logic       m_rng = 1'b0;
    logic [6:0] m_addr = 7'h00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] exp_q[$];

    function automatic int done_pos(input logic rng);
        return rng ? 1 : T_NORM;
    endfunction

    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_t = 0; m_wr = 1'b0; m_rng = 1'b0;
            m_addr = 7'h00; m_data = 8'h00; m_rdata = 8'h00;
            exp_q.delete();
        end else if (m_t == 0) begin
            if (req_in) begin
                m_wr  = wr_in;
                m_rng = RANGE_EN && addr_in[7];
                if (m_rng) begin
                    if (!wr_in) begin
                        m_rdata = 8'h00;
                        exp_q.push_back(8'h00);
                    end
                end else begin
                    m_addr = addr_in[6:0];
                    m_data = wdata_in;
                end
                m_t = 1;
            end
        end else begin
            if (!m_rng && !m_wr && m_t == S + ST) begin
                m_rdata = pin_data_in;
                exp_q.push_back(pin_data_in);
            end
            m_t = (m_t == done_pos(m_rng)) ? 0 : m_t + 1;
        end
    end

    // ---------------- compare process ----------------
    logic e_busy, e_ack, e_err, e_we, e_drive;
    logic [7:0] e_rd;

    always @(posedge clk_in) begin
        #1;
        e_busy  = (m_t != 0);
        e_ack   = (m_t != 0) && (m_t == done_pos(m_rng));
        e_err   = e_ack && m_rng;
        e_we    = !m_rng && m_wr && (m_t >= S + 1) && (m_t <= S + ST);
        e_drive = !m_rng && m_wr && (m_t >= 1) && (m_t <= S + ST + H);
        check("busy", 8'(busy_out), 8'(e_busy));
        check("ack", 8'(ack_out), 8'(e_ack));
        check("err", 8'(err_out), 8'(e_err));
        check("we", 8'(pin_we_out), 8'(e_we));
        check("drive", 8'(pin_drive_out), 8'(e_drive));
        check("pin_addr", 8'(pin_addr_out), 8'(m_addr));
        check("pin_data", pin_data_out, m_data);
        check("rdata", rdata_out, m_rdata);
        if (ack_out === 1'b1) ack_total++;
        if (e_ack && !m_wr) begin
            if (exp_q.size() == 0) begin
                check("rd_q_empty", 8'd0, 8'd1);
            end else begin
                e_rd = exp_q.pop_front();
                check("rd_at_ack", rdata_out, e_rd);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_access(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                              input bit read_pattern, output int ack_lat, output int we_n,
                              output int we_first, output int drive_n, output logic err_seen);
        @(negedge clk_in);
        req_in = 1'b1; wr_in = wr; addr_in = addr; wdata_in = wdata; pin_data_in = 8'hFF;
        ack_lat = 0; we_n = 0; we_first = 0; drive_n = 0; err_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (k == 1) req_in = 1'b0;
            if (pin_we_out) begin
                we_n++;
                if (we_first == 0) we_first = k;
            end
            if (pin_drive_out) drive_n++;
            if (read_pattern) pin_data_in = (k >= S + 1 && k <= S + ST) ? 8'h5A : 8'hFF;
            if (ack_out) begin
                ack_lat = k;
                err_seen = err_out;
                break;
            end
        end
        pin_data_in = 8'hFF;
        if (ack_lat == 0) check("ack_timeout", 8'd0, 8'd1);
    endtask

    int   lat, wen, wfirst, drn, a0, first_ack, second_ack;
    logic errs;

    initial begin
        // reset held three edges with a pending request
        rst_in = 1'b0; req_in = 1'b1; wr_in = 1'b1; addr_in = 8'h15; wdata_in = 8'hA5;
        repeat (3) @(negedge clk_in);
        check("rst_busy", 8'(busy_out), 8'd0);
        check("rst_we", 8'(pin_we_out), 8'd0);
        check("rst_addr", 8'(pin_addr_out), 8'd0);
        req_in = 1'b0; rst_in = 1'b1;
        @(negedge clk_in);

        // default read at 3C, 5A on pins during the strobe window
        run_access(1'b0, 8'h3C, 8'h00, 1'b1, lat, wen, wfirst, drn, errs);
        check("rd_lat", 8'(lat), 8'd5);
        check("rd_drive_n", 8'(drn), 8'd0);
        check("rd_data", rdata_out, 8'h5A);
        @(negedge clk_in);

        // default write 15 <- A5
        run_access(1'b1, 8'h15, 8'hA5, 1'b0, lat, wen, wfirst, drn, errs);
        check("wr_lat", 8'(lat), 8'd5);
        check("wr_we_n", 8'(wen), 8'd2);
        check("wr_we_first", 8'(wfirst), 8'd2);
        check("wr_drive_n", 8'(drn), 8'd4);
        check("wr_pin_addr", 8'(pin_addr_out), 8'h15);
        check("wr_pin_data", pin_data_out, 8'hA5);
        check("wr_rdata_kept", rdata_out, 8'h5A);
        @(negedge clk_in);

        // read at 80: range error or aliased access
        run_access(1'b0, 8'h80, 8'h00, 1'b1, lat, wen, wfirst, drn, errs);
        if (RANGE_EN) begin
            check("rng_lat", 8'(lat), 8'd1);
            check("rng_err", 8'(errs), 8'd1);
            check("rng_rdata", rdata_out, 8'h00);
            check("rng_pin_addr", 8'(pin_addr_out), 8'h15);
            check("rng_drive_n", 8'(drn), 8'd0);
        end else begin
            check("alias_lat", 8'(lat), 8'd5);
            check("alias_err", 8'(errs), 8'd0);
            check("alias_pin_addr", 8'(pin_addr_out), 8'h00);
            check("alias_rdata", rdata_out, 8'h5A);
        end
        @(negedge clk_in);

        // req held high across two writes: one idle cycle between accesses
        a0 = ack_total; first_ack = 0; second_ack = 0;
        req_in = 1'b1; wr_in = 1'b1; addr_in = 8'h22; wdata_in = 8'h11;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (ack_out) begin
                if (first_ack == 0) first_ack = k;
                else begin
                    second_ack = k;
                    req_in = 1'b0;
                    break;
                end
            end
        end
        req_in = 1'b0;
        check("b2b_gap", 8'(second_ack - first_ack), 8'(T_NORM + 1));
        repeat (10) @(negedge clk_in);
        check("b2b_acks", 8'(ack_total - a0), 8'd2);

        // request pulses while busy are ignored
        a0 = ack_total;
        req_in = 1'b1; wr_in = 1'b0; addr_in = 8'h07;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk_in);
            req_in = (k == 2 || k == 4) ? 1'b1 : 1'b0;
        end
        req_in = 1'b0;
        check("busy_pulse_acks", 8'(ack_total - a0), 8'd1);

        // reset during the strobe of a write
        @(negedge clk_in);
        req_in = 1'b1; wr_in = 1'b1; addr_in = 8'h15; wdata_in = 8'h3C;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_in);
            if (k == 1) req_in = 1'b0;
            if (k == 2) rst_in = 1'b0;
            if (k == 3) begin
                check("abort_we", 8'(pin_we_out), 8'd0);
                check("abort_drive", 8'(pin_drive_out), 8'd0);
                check("abort_busy", 8'(busy_out), 8'd0);
                check("abort_rdata", rdata_out, 8'h00);
                rst_in = 1'b1;
            end
        end
        a0 = ack_total;
        repeat (10) @(negedge clk_in);
        check("abort_no_ack", 8'(ack_total - a0), 8'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_in);
            rst_in      = ($urandom_range(0, 149) != 0);
            req_in      = ($urandom_range(0, 2) == 0);
            wr_in       = 1'($urandom_range(0, 1));
            addr_in     = 8'($urandom_range(0, 255));
            wdata_in    = 8'($urandom_range(0, 255));
            pin_data_in = 8'($urandom_range(0, 255));
        end
        rst_in = 1'b1; req_in = 1'b0;
        repeat (20) @(negedge clk_in);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
